// File: rtl/cpu_bus_mux_pkg.sv
// Shared definitions for the CPU bus mux: FSM states, slot-index macros, SLOT_LAT builder.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Header: BM_SLOT_* name slot indices; BM_LAT(slot, n) places n wait states in a slot's
// field of SLOT_LAT, assuming the default 4-bit LAT_W. OR the terms together and size the
// result to SLOTS*LAT_W bits at the instantiation.
`ifndef CPU_BUS_MUX_DEFS_SVH
`define CPU_BUS_MUX_DEFS_SVH
`define BM_SLOT_0  0
`define BM_SLOT_1  1
`define BM_SLOT_2  2
`define BM_SLOT_3  3
`define BM_SLOT_4  4
`define BM_SLOT_5  5
`define BM_SLOT_6  6
`define BM_SLOT_7  7
`define BM_SLOT_8  8
`define BM_SLOT_9  9
`define BM_SLOT_10 10
`define BM_SLOT_11 11
`define BM_SLOT_12 12
`define BM_SLOT_13 13
`define BM_SLOT_14 14
`define BM_SLOT_15 15
`define BM_LAT(slot, n) (64'(n) << ((slot) * 4))
`endif

package cpu_bus_mux_pkg;

    typedef enum logic [1:0] {
        BM_IDLE = 2'd0,
        BM_WAIT = 2'd1,
        BM_DONE = 2'd2
    } bm_state_t;

    // Index width that stays legal for a single-slot build.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_bus_mux_priority_encoder.sv
// Priority encoder: any-hot request vector -> lowest set index plus hit flag.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of req.
// Ports: req (N bits in), idx (lowest set index out), hit (any bit set out).
module priority_encoder #(
    parameter int N     = 8,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             hit
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_mux.sv
// CPU-side read mux / ready generator over SLOTS peripheral slots, one access at a time.
// Latency: fixed slot with n wait states completes n+1 cycles after cpu_valid; handshake slot one cycle after slot_ready.
// Backpressure: cpu_valid held until the one-cycle cpu_ready pulse; dropping it in WAIT aborts silently.
// Ports: clk/reset_n (async active-low); cpu_valid, cpu_wstrb (0 = read); slot_en, slot_ready,
// slot_read_data (packed per slot); cpu_ready, cpu_read_data (registered), cpu_bus_error, active_slot.
// Build option CPU_BUS_TIMEOUT_EN: adds the WAIT timeout counter and error reporting for
// timeouts and unmapped accesses; without it cpu_bus_error is constant 0.
module cpu_bus_mux
    import cpu_bus_mux_pkg::*;
#(
    parameter int                     SLOTS          = 8,
    parameter int                     DATA_W         = 32,
    parameter int                     LAT_W          = 4,
    parameter logic [SLOTS*LAT_W-1:0] SLOT_LAT       = '0,
    parameter logic [SLOTS-1:0]       SLOT_HANDSHAKE = '0,
    parameter logic [SLOTS-1:0]       READ_SOURCES   = '1,
    parameter int                     TIMEOUT_CYCLES = 255,
    localparam int                    IDX_W          = idx_w(SLOTS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpu_valid,
    input  logic [DATA_W/8-1:0]     cpu_wstrb,
    input  logic [SLOTS-1:0]        slot_en,
    input  logic [SLOTS-1:0]        slot_ready,
    input  logic [SLOTS*DATA_W-1:0] slot_read_data,
    output logic                    cpu_ready,
    output logic [DATA_W-1:0]       cpu_read_data,
    output logic                    cpu_bus_error,
    output logic [IDX_W-1:0]        active_slot
);

`ifdef CPU_BUS_TIMEOUT_EN
    localparam int               TO_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = '1;
`else
    localparam logic [DATA_W-1:0] UNMAPPED_DATA = '0;
`endif

    bm_state_t        state;
    logic [LAT_W-1:0] wait_cnt;
`ifdef CPU_BUS_TIMEOUT_EN
    logic [TO_W-1:0]  to_cnt;
`endif

    logic [IDX_W-1:0]  enc_idx;
    logic              enc_hit;
    logic [IDX_W-1:0]  cur_slot;
    logic              cur_hs;
    logic [LAT_W-1:0]  cur_lat;
    logic [DATA_W-1:0] cur_rdata;
    logic              cur_done;
    logic              is_read;

    priority_encoder #(
        .N     (SLOTS),
        .IDX_W (IDX_W)
    ) u_enc (
        .req (slot_en),
        .idx (enc_idx),
        .hit (enc_hit)
    );

    // In IDLE the decoder picks the slot; afterwards the latched slot rules, so slot_en
    // wiggling during WAIT cannot redirect the access.
    always_comb begin
        cur_slot  = (state == BM_IDLE) ? enc_idx : active_slot;
        cur_hs    = SLOT_HANDSHAKE[cur_slot];
        cur_lat   = SLOT_LAT[cur_slot*LAT_W +: LAT_W];
        cur_rdata = READ_SOURCES[cur_slot] ? slot_read_data[cur_slot*DATA_W +: DATA_W] : '0;
        is_read   = (cpu_wstrb == '0);
        if (cur_hs) begin
            cur_done = slot_ready[cur_slot];
        end else if (state == BM_IDLE) begin
            cur_done = (cur_lat == '0);
        end else begin
            cur_done = (wait_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BM_IDLE;
            wait_cnt      <= '0;
            active_slot   <= '0;
            cpu_ready     <= 1'b0;
            cpu_read_data <= '0;
`ifdef CPU_BUS_TIMEOUT_EN
            to_cnt        <= '0;
            cpu_bus_error <= 1'b0;
`endif
        end else begin
            cpu_ready <= 1'b0;
`ifdef CPU_BUS_TIMEOUT_EN
            cpu_bus_error <= 1'b0;
`endif
            case (state)
                BM_IDLE: begin
                    if (cpu_valid && enc_hit) begin
                        active_slot <= enc_idx;
                        if (cur_done) begin
                            if (is_read) cpu_read_data <= cur_rdata;
                            cpu_ready <= 1'b1;
                            state     <= BM_DONE;
                        end else begin
                            // Fixed slot with n wait states: n-1 here, then count down to 0.
                            wait_cnt <= cur_hs ? '0 : cur_lat - 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                            state    <= BM_WAIT;
                        end
                    end else if (cpu_valid) begin
                        cpu_read_data <= UNMAPPED_DATA;
                        cpu_ready     <= 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
                        cpu_bus_error <= 1'b1;
`endif
                        state         <= BM_DONE;
                    end
                end
                BM_WAIT: begin
                    if (!cpu_valid) begin
                        state <= BM_IDLE;
                    end else if (cur_done) begin
                        if (is_read) cpu_read_data <= cur_rdata;
                        cpu_ready <= 1'b1;
                        state     <= BM_DONE;
                    end else begin
                        if (!cur_hs) wait_cnt <= wait_cnt - 1'b1;
`ifdef CPU_BUS_TIMEOUT_EN
                        // Counter holds completed WAIT cycles; this is the last allowed one.
                        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            cpu_read_data <= '1;
                            cpu_ready     <= 1'b1;
                            cpu_bus_error <= 1'b1;
                            state         <= BM_DONE;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                // cpu_valid is deliberately ignored here so a held request is not completed twice.
                BM_DONE: state <= BM_IDLE;
                default: state <= BM_IDLE;
            endcase
        end
    end

`ifndef CPU_BUS_TIMEOUT_EN
    assign cpu_bus_error = 1'b0;
`endif

endmodule
